// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port.
// Single outstanding request, fixed wait states, registered one-cycle response.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          DEPTH = 2 ** (ADDR_W - 2);
    localparam int          LANES = DATA_W / 8;
    localparam logic [3:0]  WC    = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;

    logic [DATA_W-1:0] rd_q;
    logic              err_q;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              accept;
    logic              enter_resp;
    logic              src_we;
    logic [31:0]       src_addr;
    logic [DATA_W-1:0] src_wdata;
    logic [3:0]        src_be;
    logic              src_err;
    logic [ADDR_W-3:0] src_idx;

    assign idle      = (state_q == S_IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && idle;

    // With zero wait states RESP is entered at the accept edge itself,
    // so the access must use the live request rather than the latched copy.
    assign src_we    = idle ? req_we    : we_q;
    assign src_addr  = idle ? req_addr  : addr_q;
    assign src_wdata = idle ? req_wdata : wdata_q;
    assign src_be    = idle ? req_be    : be_q;
    assign src_idx   = src_addr[ADDR_W-1:2];
    assign src_err   = (|src_addr[1:0]) | (|src_addr[31:ADDR_W]);

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state logic: accept, count wait states, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WC == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WC) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and request latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    // Capture load data and error flag at the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= src_err;
            rd_q  <= (src_we || src_err) ? '0 : mem[src_idx];
        end
    end

    // Response outputs: one registered pulse following the RESP cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == S_RESP);
            rsp_rdata_q <= (state_q == S_RESP) ? rd_q : '0;
            rsp_err_q   <= (state_q == S_RESP) ? err_q : 1'b0;
        end
    end

    // Byte-lane store commit; reset asserted at this edge drops the write.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && src_we && !src_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (src_be[i]) begin
                    mem[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder.
// Instance a uses two wait states, instance b uses none.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_we, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;

    logic        b_valid, b_ready, b_we, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int total;
    int bad;

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_a (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_we    (a_we),
        .req_addr  (a_addr),
        .req_wdata (a_wdata),
        .req_be    (a_be),
        .rsp_valid (a_rvalid),
        .rsp_rdata (a_rdata),
        .rsp_err   (a_err)
    );

    dmem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_b (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_we    (b_we),
        .req_addr  (b_addr),
        .req_wdata (b_wdata),
        .req_be    (b_be),
        .rsp_valid (b_rvalid),
        .rsp_rdata (b_rdata),
        .rsp_err   (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request on instance a from IDLE and watch 8 edges after accept.
    task automatic txn(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int npulse);
        rdata  = 32'hX;
        err    = 1'bX;
        lat    = -1;
        npulse = 0;
        @(negedge clk);
        a_we    = we;
        a_addr  = addr;
        a_wdata = wdata;
        a_be    = be;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        a_addr  = 32'hFFFF_FFFF;
        a_wdata = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_rvalid) begin
                npulse++;
                if (lat < 0) begin
                    lat   = i;
                    rdata = a_rdata;
                    err   = a_err;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", a_ready);
        end
        total++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_rsp got=%b/%h/%b want=0/0/0",
                     a_rvalid, a_rdata, a_err);
        end
        total++;
        if (b_ready !== 1'b1 || b_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_b got=%b/%b want=1/0", b_ready, b_rvalid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        er;
        int          lat, np;
        txn(1'b1, 32'h04, 32'h1234_5678, 4'b1111, rd, er, lat, np);
        total++;
        if (lat !== 3 || np !== 1) begin
            bad++;
            $display("FAIL store_latency got=%0d/%0d want=3/1", lat, np);
        end
        total++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            bad++;
            $display("FAIL store_rsp got=%b/%h want=0/0", er, rd);
        end
        txn(1'b0, 32'h04, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (rd !== 32'h1234_5678 || er !== 1'b0 || lat !== 3) begin
            bad++;
            $display("FAIL load_04 got=%h/%b/%0d want=12345678/0/3",
                     rd, er, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic        er;
        int          lat, np;
        int          pulses;
        txn(1'b1, 32'h10, 32'h1111_1111, 4'b1111, rd, er, lat, np);
        pulses = 0;
        @(negedge clk);
        a_we    = 1'b1;
        a_addr  = 32'h10;
        a_wdata = 32'hDEAD_BEEF;
        a_be    = 4'b1111;
        a_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_rvalid) pulses++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_rvalid) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_pulse got=%0d want=0", pulses);
        end
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_ready got=%b want=1", a_ready);
        end
        txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (rd !== 32'h1111_1111 || er !== 1'b0) begin
            bad++;
            $display("FAIL abort_load got=%h/%b want=11111111/0", rd, er);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        int          lat, np;
        txn(1'b1, 32'h08, 32'hAABB_CCDD, 4'b1111, rd, er, lat, np);
        txn(1'b1, 32'h08, 32'h0000_0011, 4'b0001, rd, er, lat, np);
        txn(1'b0, 32'h08, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (rd !== 32'hAABB_CC11) begin
            bad++;
            $display("FAIL lane_merge got=%h want=aabbcc11", rd);
        end
        txn(1'b1, 32'h08, 32'hFFFF_FFFF, 4'b0000, rd, er, lat, np);
        total++;
        if (er !== 1'b0 || np !== 1) begin
            bad++;
            $display("FAIL be0_rsp got=%b/%0d want=0/1", er, np);
        end
        txn(1'b1, 32'h08, 32'h5566_7788, 4'b1010, rd, er, lat, np);
        txn(1'b0, 32'h08, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (rd !== 32'h55BB_77_11) begin
            bad++;
            $display("FAIL lane_1010 got=%h want=55bb7711", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat, np;
        txn(1'b0, 32'h06, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 3) begin
            bad++;
            $display("FAIL err_misalign got=%b/%h/%0d want=1/0/3",
                     er, rd, lat);
        end
        txn(1'b0, 32'h100, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            bad++;
            $display("FAIL err_range got=%b/%h want=1/0", er, rd);
        end
        txn(1'b1, 32'h104, 32'hBAD0_BAD0, 4'b1111, rd, er, lat, np);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL err_store got=%b want=1", er);
        end
        txn(1'b1, 32'h05, 32'hBAD1_BAD1, 4'b1111, rd, er, lat, np);
        txn(1'b0, 32'h04, 32'h0, 4'b0000, rd, er, lat, np);
        total++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            bad++;
            $display("FAIL err_nowrite got=%h/%b want=12345678/0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        a_we    = 1'b0;
        a_addr  = 32'h04;
        a_wdata = 32'h0;
        a_be    = 4'b0000;
        a_valid = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 15) a_valid = 1'b0;
            total++;
            if (a_ready !== ((e % 4) == 3)) begin
                bad++;
                $display("FAIL b2b_ready edge=%0d got=%b want=%b",
                         e, a_ready, (e % 4) == 3);
            end
            total++;
            if (a_rvalid !== ((e % 4) == 3)) begin
                bad++;
                $display("FAIL b2b_rvalid edge=%0d got=%b want=%b",
                         e, a_rvalid, (e % 4) == 3);
            end
            if (a_rvalid) begin
                pulses++;
                total++;
                if (a_rdata !== 32'h1234_5678) begin
                    bad++;
                    $display("FAIL b2b_data got=%h want=12345678", a_rdata);
                end
            end
        end
        total++;
        if (pulses !== 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=4", pulses);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        b_we    = 1'b1;
        b_addr  = 32'h20;
        b_wdata = 32'hCAFE_F00D;
        b_be    = 4'b1111;
        b_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_we   = 1'b0;
        b_wdata = 32'h0;
        total++;
        if (b_ready !== 1'b0 || b_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL zw_e0 got=%b/%b want=0/0", b_ready, b_rvalid);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (b_rvalid !== 1'b1 || b_ready !== 1'b1 || b_err !== 1'b0) begin
            bad++;
            $display("FAIL zw_e1 got=%b/%b/%b want=1/1/0",
                     b_rvalid, b_ready, b_err);
        end
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        total++;
        if (b_ready !== 1'b0 || b_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL zw_e2 got=%b/%b want=0/0", b_ready, b_rvalid);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL zw_load got=%b/%h want=1/cafef00d",
                     b_rvalid, b_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (b_rvalid !== 1'b0 || b_rdata !== 32'h0) begin
            bad++;
            $display("FAIL zw_idle got=%b/%h want=0/0", b_rvalid, b_rdata);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_we    = 1'b0;
        a_addr  = 32'h0;
        a_wdata = 32'h0;
        a_be    = 4'b0000;
        b_valid = 1'b0;
        b_we    = 1'b0;
        b_addr  = 32'h0;
        b_wdata = 32'h0;
        b_be    = 4'b0000;
        test_reset();
        test_store_load();
        test_reset_abort();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_zero_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
